// File: rtl/nasti_pkg.sv
// Shared NASTI constants and helpers.
//   BURST_INCR            : AxBURST encoding for incrementing bursts
//   RESP_*                : xRESP encodings
//   size_of_bytes(n)      : AxSIZE encoding for an n-byte beat (n a power of two)
package nasti_pkg;

  localparam logic [1:0] BURST_INCR  = 2'b01;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  function automatic logic [2:0] size_of_bytes(input int unsigned n);
    logic [2:0] s;
    s = '0;
    for (int unsigned i = 0; i < 8; i++) begin
      if ((32'd1 << i) == n) s = 3'(i);
    end
    return s;
  endfunction

endpackage

// File: rtl/nasti_lite_fifo.sv
// In-order tracker FIFO for lite_nasti_reader.
//   clk, rst : clock, synchronous active-high reset (clears pointers/count)
//   push/din : write an entry (ignored when full)
//   pop      : discard the head entry (ignored when empty)
//   dout     : head entry
//   full     : DEPTH entries held
//   empty    : no entries held
module nasti_lite_fifo #(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic             do_push;
  logic             do_pop;

  // Pointers wrap at DEPTH, which need not be a power of two.
  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= next_ptr(wr_ptr);
      if (do_pop)  rd_ptr <= next_ptr(rd_ptr);
      if (do_push && !do_pop)      count <= count + 1'b1;
      else if (do_pop && !do_push) count <= count - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/lite_nasti_reader.sv
// Read-channel upsizer: NASTI-Lite master (narrow, single beat) to NASTI slave
// (wide data). Each Lite read becomes a single-beat NASTI burst issued with
// ID 0, so the slave returns beats in order; the Lite ID and lane are restored
// from an in-order tracker.
//   clk, rst      : clock, synchronous active-high reset
//   lite_ar_*     : Lite read request (in), lite_ar_ready out
//   lite_r_*      : Lite read response (out, registered), lite_r_ready in
//   nasti_ar_*    : NASTI read request (out, registered), nasti_ar_ready in
//   nasti_r_*     : NASTI read response (in), nasti_r_ready out
module lite_nasti_reader
  import nasti_pkg::*;
#(
  parameter int unsigned MAX_TRANSACTION  = 2,
  parameter int unsigned ID_WIDTH         = 1,
  parameter int unsigned ADDR_WIDTH       = 12,
  parameter int unsigned NASTI_DATA_WIDTH = 64,
  parameter int unsigned LITE_DATA_WIDTH  = 32,
  parameter int unsigned USER_WIDTH       = 1
) (
  input  logic                        clk,
  input  logic                        rst,

  input  logic [ID_WIDTH-1:0]         lite_ar_id,
  input  logic [ADDR_WIDTH-1:0]       lite_ar_addr,
  input  logic [2:0]                  lite_ar_prot,
  input  logic [3:0]                  lite_ar_qos,
  input  logic [3:0]                  lite_ar_region,
  input  logic [USER_WIDTH-1:0]       lite_ar_user,
  input  logic                        lite_ar_valid,
  output logic                        lite_ar_ready,

  output logic [ID_WIDTH-1:0]         lite_r_id,
  output logic [LITE_DATA_WIDTH-1:0]  lite_r_data,
  output logic [1:0]                  lite_r_resp,
  output logic [USER_WIDTH-1:0]       lite_r_user,
  output logic                        lite_r_valid,
  input  logic                        lite_r_ready,

  output logic [ID_WIDTH-1:0]         nasti_ar_id,
  output logic [ADDR_WIDTH-1:0]       nasti_ar_addr,
  output logic [7:0]                  nasti_ar_len,
  output logic [2:0]                  nasti_ar_size,
  output logic [1:0]                  nasti_ar_burst,
  output logic                        nasti_ar_lock,
  output logic [3:0]                  nasti_ar_cache,
  output logic [2:0]                  nasti_ar_prot,
  output logic [3:0]                  nasti_ar_qos,
  output logic [3:0]                  nasti_ar_region,
  output logic [USER_WIDTH-1:0]       nasti_ar_user,
  output logic                        nasti_ar_valid,
  input  logic                        nasti_ar_ready,

  input  logic [ID_WIDTH-1:0]         nasti_r_id,
  input  logic [NASTI_DATA_WIDTH-1:0] nasti_r_data,
  input  logic [1:0]                  nasti_r_resp,
  input  logic                        nasti_r_last,
  input  logic [USER_WIDTH-1:0]       nasti_r_user,
  input  logic                        nasti_r_valid,
  output logic                        nasti_r_ready
);

  localparam int unsigned LANES   = NASTI_DATA_WIDTH / LITE_DATA_WIDTH;
  localparam int unsigned LANE_W  = $clog2(LANES);
  // Tracker always carries at least one lane bit; it is tied to 0 when
  // the two widths match.
  localparam int unsigned LANE_SW = (LANE_W > 0) ? LANE_W : 1;
  localparam int unsigned TRACK_W = ID_WIDTH + LANE_SW;
  localparam int unsigned LANE_LO = $clog2(LITE_DATA_WIDTH / 8);
  localparam logic [2:0]  AR_SIZE = size_of_bytes(LITE_DATA_WIDTH / 8);

  logic               ar_fire;
  logic               r_fire;
  logic               trk_full;
  logic               trk_empty;
  logic [LANE_SW-1:0] ar_lane;
  logic [TRACK_W-1:0] trk_din;
  logic [TRACK_W-1:0] trk_dout;
  logic [ID_WIDTH-1:0] head_id;
  logic [LANE_SW-1:0] head_lane;

  // The R ID is meaningless: everything goes out as ID 0 and comes back in order.
  logic unused_r_id;
  assign unused_r_id = ^nasti_r_id;

  generate
    if (LANE_W > 0) begin : g_lane
      assign ar_lane = lite_ar_addr[LANE_LO + LANE_W - 1 : LANE_LO];
    end else begin : g_no_lane
      assign ar_lane = '0;
    end
  endgenerate

  // Tracker occupancy is the outstanding-transaction count: full means
  // count==MAX_TRANSACTION, empty means count==0. A same-cycle pop does not
  // free a slot for the request in that cycle.
  assign lite_ar_ready = !rst && !trk_full && (!nasti_ar_valid || nasti_ar_ready);
  assign nasti_r_ready = !rst && !trk_empty && (!lite_r_valid || lite_r_ready);
  assign ar_fire       = lite_ar_valid && lite_ar_ready;
  assign r_fire        = nasti_r_valid && nasti_r_ready;

  assign trk_din                = {lite_ar_id, ar_lane};
  assign {head_id, head_lane}   = trk_dout;

  nasti_lite_fifo #(
    .DEPTH (MAX_TRANSACTION),
    .WIDTH (TRACK_W)
  ) u_tracker (
    .clk   (clk),
    .rst   (rst),
    .push  (ar_fire),
    .pop   (r_fire),
    .din   (trk_din),
    .dout  (trk_dout),
    .full  (trk_full),
    .empty (trk_empty)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      nasti_ar_valid  <= 1'b0;
      nasti_ar_id     <= '0;
      nasti_ar_addr   <= '0;
      nasti_ar_len    <= '0;
      nasti_ar_size   <= '0;
      nasti_ar_burst  <= '0;
      nasti_ar_lock   <= 1'b0;
      nasti_ar_cache  <= '0;
      nasti_ar_prot   <= '0;
      nasti_ar_qos    <= '0;
      nasti_ar_region <= '0;
      nasti_ar_user   <= '0;
    end else if (ar_fire) begin
      nasti_ar_valid  <= 1'b1;
      nasti_ar_id     <= '0;
      nasti_ar_addr   <= lite_ar_addr;
      nasti_ar_len    <= '0;
      nasti_ar_size   <= AR_SIZE;
      nasti_ar_burst  <= BURST_INCR;
      nasti_ar_lock   <= 1'b0;
      nasti_ar_cache  <= '0;
      nasti_ar_prot   <= lite_ar_prot;
      nasti_ar_qos    <= lite_ar_qos;
      nasti_ar_region <= lite_ar_region;
      nasti_ar_user   <= lite_ar_user;
    end else if (nasti_ar_ready) begin
      nasti_ar_valid  <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      lite_r_valid <= 1'b0;
      lite_r_id    <= '0;
      lite_r_data  <= '0;
      lite_r_resp  <= '0;
      lite_r_user  <= '0;
    end else if (r_fire) begin
      lite_r_valid <= 1'b1;
      lite_r_id    <= head_id;
      lite_r_data  <= nasti_r_data[int'(head_lane) * LITE_DATA_WIDTH +: LITE_DATA_WIDTH];
      // A beat without last is a malformed burst; it still closes the read.
      lite_r_resp  <= nasti_r_last ? nasti_r_resp : RESP_SLVERR;
      lite_r_user  <= nasti_r_user;
    end else if (lite_r_ready) begin
      lite_r_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_lite_nasti_reader.sv
module tb_lite_nasti_reader;

  logic        clk = 1'b0;
  logic        rst;
  logic [0:0]  lite_ar_id;
  logic [11:0] lite_ar_addr;
  logic [2:0]  lite_ar_prot;
  logic [3:0]  lite_ar_qos;
  logic [3:0]  lite_ar_region;
  logic [0:0]  lite_ar_user;
  logic        lite_ar_valid;
  logic        lite_ar_ready;
  logic [0:0]  lite_r_id;
  logic [31:0] lite_r_data;
  logic [1:0]  lite_r_resp;
  logic [0:0]  lite_r_user;
  logic        lite_r_valid;
  logic        lite_r_ready;
  logic [0:0]  nasti_ar_id;
  logic [11:0] nasti_ar_addr;
  logic [7:0]  nasti_ar_len;
  logic [2:0]  nasti_ar_size;
  logic [1:0]  nasti_ar_burst;
  logic        nasti_ar_lock;
  logic [3:0]  nasti_ar_cache;
  logic [2:0]  nasti_ar_prot;
  logic [3:0]  nasti_ar_qos;
  logic [3:0]  nasti_ar_region;
  logic [0:0]  nasti_ar_user;
  logic        nasti_ar_valid;
  logic        nasti_ar_ready;
  logic [0:0]  nasti_r_id;
  logic [63:0] nasti_r_data;
  logic [1:0]  nasti_r_resp;
  logic        nasti_r_last;
  logic [0:0]  nasti_r_user;
  logic        nasti_r_valid;
  logic        nasti_r_ready;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [0:0]  id;
    logic [11:0] addr;
    logic [2:0]  prot;
    logic [3:0]  qos;
    logic [3:0]  region;
    logic [0:0]  user;
  } ar_t;

  typedef struct {
    logic [0:0]  id;
    logic [31:0] data;
    logic [1:0]  resp;
    logic [0:0]  user;
  } r_t;

  ar_t ar_q[$];
  ar_t trk_q[$];
  r_t  r_q[$];

  lite_nasti_reader #(
    .MAX_TRANSACTION  (2),
    .ID_WIDTH         (1),
    .ADDR_WIDTH       (12),
    .NASTI_DATA_WIDTH (64),
    .LITE_DATA_WIDTH  (32),
    .USER_WIDTH       (1)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .lite_ar_id      (lite_ar_id),
    .lite_ar_addr    (lite_ar_addr),
    .lite_ar_prot    (lite_ar_prot),
    .lite_ar_qos     (lite_ar_qos),
    .lite_ar_region  (lite_ar_region),
    .lite_ar_user    (lite_ar_user),
    .lite_ar_valid   (lite_ar_valid),
    .lite_ar_ready   (lite_ar_ready),
    .lite_r_id       (lite_r_id),
    .lite_r_data     (lite_r_data),
    .lite_r_resp     (lite_r_resp),
    .lite_r_user     (lite_r_user),
    .lite_r_valid    (lite_r_valid),
    .lite_r_ready    (lite_r_ready),
    .nasti_ar_id     (nasti_ar_id),
    .nasti_ar_addr   (nasti_ar_addr),
    .nasti_ar_len    (nasti_ar_len),
    .nasti_ar_size   (nasti_ar_size),
    .nasti_ar_burst  (nasti_ar_burst),
    .nasti_ar_lock   (nasti_ar_lock),
    .nasti_ar_cache  (nasti_ar_cache),
    .nasti_ar_prot   (nasti_ar_prot),
    .nasti_ar_qos    (nasti_ar_qos),
    .nasti_ar_region (nasti_ar_region),
    .nasti_ar_user   (nasti_ar_user),
    .nasti_ar_valid  (nasti_ar_valid),
    .nasti_ar_ready  (nasti_ar_ready),
    .nasti_r_id      (nasti_r_id),
    .nasti_r_data    (nasti_r_data),
    .nasti_r_resp    (nasti_r_resp),
    .nasti_r_last    (nasti_r_last),
    .nasti_r_user    (nasti_r_user),
    .nasti_r_valid   (nasti_r_valid),
    .nasti_r_ready   (nasti_r_ready)
  );

  always #5 clk = ~clk;

  // Scoreboard: inputs change #1 after posedge, so the negedge sees the
  // values that the next posedge will act on. Older entries are retired
  // before new ones are queued.
  always @(negedge clk) begin
    if (nasti_ar_valid && nasti_ar_ready) begin
      ar_t e;
      checks++;
      if (ar_q.size() == 0) begin
        errors++;
        $display("FAIL nasti_ar_unexpected got addr %h exp none", nasti_ar_addr);
      end else begin
        e = ar_q.pop_front();
        if ({nasti_ar_id, nasti_ar_addr, nasti_ar_len, nasti_ar_size, nasti_ar_burst,
             nasti_ar_lock, nasti_ar_cache, nasti_ar_prot, nasti_ar_qos, nasti_ar_region,
             nasti_ar_user} !==
            {1'b0, e.addr, 8'd0, 3'd2, 2'b01, 1'b0, 4'd0, e.prot, e.qos, e.region, e.user}) begin
          errors++;
          $display("FAIL nasti_ar_payload got id %h addr %h len %h size %h burst %h lock %b cache %h prot %h qos %h region %h user %h exp addr %h prot %h qos %h region %h user %h",
                   nasti_ar_id, nasti_ar_addr, nasti_ar_len, nasti_ar_size, nasti_ar_burst,
                   nasti_ar_lock, nasti_ar_cache, nasti_ar_prot, nasti_ar_qos, nasti_ar_region,
                   nasti_ar_user, e.addr, e.prot, e.qos, e.region, e.user);
        end
      end
    end
    if (!rst && lite_ar_valid && lite_ar_ready) begin
      ar_t a;
      a.id = lite_ar_id; a.addr = lite_ar_addr; a.prot = lite_ar_prot;
      a.qos = lite_ar_qos; a.region = lite_ar_region; a.user = lite_ar_user;
      ar_q.push_back(a);
      trk_q.push_back(a);
    end
    if (lite_r_valid && lite_r_ready) begin
      r_t e;
      checks++;
      if (r_q.size() == 0) begin
        errors++;
        $display("FAIL lite_r_unexpected got data %h exp none", lite_r_data);
      end else begin
        e = r_q.pop_front();
        if ({lite_r_id, lite_r_data, lite_r_resp, lite_r_user} !== {e.id, e.data, e.resp, e.user}) begin
          errors++;
          $display("FAIL lite_r_payload got id %h data %h resp %h user %h exp id %h data %h resp %h user %h",
                   lite_r_id, lite_r_data, lite_r_resp, lite_r_user, e.id, e.data, e.resp, e.user);
        end
      end
    end
    if (nasti_r_valid && nasti_r_ready) begin
      ar_t t;
      r_t  x;
      if (trk_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL nasti_r_accept_empty got accept exp none outstanding");
      end else begin
        t = trk_q.pop_front();
        x.id   = t.id;
        x.data = t.addr[2] ? nasti_r_data[63:32] : nasti_r_data[31:0];
        x.resp = nasti_r_last ? nasti_r_resp : 2'b10;
        x.user = nasti_r_user;
        r_q.push_back(x);
      end
    end
  end

  task automatic send_ar(input logic [0:0] id, input logic [11:0] addr);
    bit done = 0;
    lite_ar_valid  = 1'b1;
    lite_ar_id     = id;
    lite_ar_addr   = addr;
    lite_ar_prot   = 3'($urandom);
    lite_ar_qos    = 4'($urandom);
    lite_ar_region = 4'($urandom);
    lite_ar_user   = 1'($urandom);
    for (int n = 0; n < 20 && !done; n++) begin
      @(negedge clk);
      done = lite_ar_ready;
      @(posedge clk); #1;
    end
    lite_ar_valid = 1'b0;
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL ar_timeout got no lite_ar_ready exp handshake addr %h", addr);
    end
  endtask

  task automatic send_r(input logic [63:0] data, input logic last, input logic [1:0] resp);
    bit done = 0;
    nasti_r_valid = 1'b1;
    nasti_r_data  = data;
    nasti_r_last  = last;
    nasti_r_resp  = resp;
    nasti_r_user  = 1'($urandom);
    nasti_r_id    = 1'($urandom);
    for (int n = 0; n < 20 && !done; n++) begin
      @(negedge clk);
      done = nasti_r_ready;
      @(posedge clk); #1;
    end
    nasti_r_valid = 1'b0;
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL r_timeout got no nasti_r_ready exp handshake data %h", data);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk); #1;
    ar_q.delete();
    trk_q.delete();
    r_q.delete();
    @(negedge clk);
    checks += 4;
    if (lite_ar_ready !== 1'b0) begin errors++; $display("FAIL rst_lite_ar_ready got %b exp 0", lite_ar_ready); end
    if (nasti_r_ready !== 1'b0) begin errors++; $display("FAIL rst_nasti_r_ready got %b exp 0", nasti_r_ready); end
    if (nasti_ar_valid !== 1'b0) begin errors++; $display("FAIL rst_nasti_ar_valid got %b exp 0", nasti_ar_valid); end
    if (lite_r_valid !== 1'b0) begin errors++; $display("FAIL rst_lite_r_valid got %b exp 0", lite_r_valid); end
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    checks += 2;
    if (lite_ar_ready !== 1'b1) begin errors++; $display("FAIL post_rst_lite_ar_ready got %b exp 1", lite_ar_ready); end
    if (nasti_r_ready !== 1'b0) begin errors++; $display("FAIL post_rst_count_zero got nasti_r_ready %b exp 0", nasti_r_ready); end
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    do_reset();
  endtask

  task automatic test_lane1();
    send_ar(1'b1, 12'h004);
    @(negedge clk);
    checks++;
    if ({nasti_ar_valid, nasti_ar_addr, nasti_ar_len, nasti_ar_size, nasti_ar_burst, nasti_ar_id} !==
        {1'b1, 12'h004, 8'd0, 3'd2, 2'b01, 1'b0}) begin
      errors++;
      $display("FAIL lane1_ar got valid %b addr %h len %h size %h burst %h id %h exp 1 004 00 2 1 0",
               nasti_ar_valid, nasti_ar_addr, nasti_ar_len, nasti_ar_size, nasti_ar_burst, nasti_ar_id);
    end
    @(posedge clk); #1;
    send_r(64'h1122334455667788, 1'b1, 2'b00);
    @(negedge clk);
    checks++;
    if ({lite_r_valid, lite_r_data, lite_r_id, lite_r_resp} !== {1'b1, 32'h11223344, 1'b1, 2'b00}) begin
      errors++;
      $display("FAIL lane1_r got valid %b data %h id %h resp %h exp 1 11223344 1 0",
               lite_r_valid, lite_r_data, lite_r_id, lite_r_resp);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_lane0();
    send_ar(1'b0, 12'h008);
    @(posedge clk); #1;
    send_r(64'h1122334455667788, 1'b1, 2'b00);
    @(negedge clk);
    checks++;
    if ({lite_r_valid, lite_r_data, lite_r_id} !== {1'b1, 32'h55667788, 1'b0}) begin
      errors++;
      $display("FAIL lane0_r got valid %b data %h id %h exp 1 55667788 0", lite_r_valid, lite_r_data, lite_r_id);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_full();
    send_ar(1'b0, 12'h000);
    send_ar(1'b1, 12'h004);
    @(negedge clk);
    checks++;
    if (lite_ar_ready !== 1'b0) begin errors++; $display("FAIL full_ready got %b exp 0", lite_ar_ready); end
    @(posedge clk); #1;
    nasti_r_valid = 1'b1;
    nasti_r_data  = 64'hCAFEF00D_0BADBEEF;
    nasti_r_last  = 1'b1;
    nasti_r_resp  = 2'b00;
    nasti_r_user  = 1'b0;
    @(negedge clk);
    checks += 2;
    if (nasti_r_ready !== 1'b1) begin errors++; $display("FAIL full_r_ready got %b exp 1", nasti_r_ready); end
    if (lite_ar_ready !== 1'b0) begin errors++; $display("FAIL full_pop_same_cycle got %b exp 0", lite_ar_ready); end
    @(posedge clk); #1;
    nasti_r_valid = 1'b0;
    @(negedge clk);
    checks += 2;
    if (lite_ar_ready !== 1'b1) begin errors++; $display("FAIL full_ready_after_pop got %b exp 1", lite_ar_ready); end
    if (lite_r_id !== 1'b0) begin errors++; $display("FAIL full_order_first got id %h exp 0", lite_r_id); end
    @(posedge clk); #1;
    send_r(64'h01234567_89ABCDEF, 1'b1, 2'b01);
    @(negedge clk);
    checks++;
    if ({lite_r_valid, lite_r_id, lite_r_data} !== {1'b1, 1'b1, 32'h01234567}) begin
      errors++;
      $display("FAIL full_order_second got valid %b id %h data %h exp 1 1 01234567", lite_r_valid, lite_r_id, lite_r_data);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_backpressure();
    lite_r_ready = 1'b0;
    send_ar(1'b0, 12'h004);
    send_ar(1'b1, 12'h008);
    @(posedge clk); #1;
    send_r(64'hAAAA5555_12345678, 1'b1, 2'b00);
    nasti_r_valid = 1'b1;
    nasti_r_data  = 64'h9999AAAA_BBBBCCCC;
    nasti_r_last  = 1'b1;
    nasti_r_resp  = 2'b00;
    nasti_r_user  = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks += 2;
      if (nasti_r_ready !== 1'b0) begin errors++; $display("FAIL bp_r_ready got %b exp 0", nasti_r_ready); end
      if ({lite_r_valid, lite_r_data, lite_r_id} !== {1'b1, 32'hAAAA5555, 1'b0}) begin
        errors++;
        $display("FAIL bp_hold got valid %b data %h id %h exp 1 aaaa5555 0", lite_r_valid, lite_r_data, lite_r_id);
      end
      @(posedge clk); #1;
    end
    lite_r_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (nasti_r_ready !== 1'b1) begin errors++; $display("FAIL bp_release_ready got %b exp 1", nasti_r_ready); end
    @(posedge clk); #1;
    nasti_r_valid = 1'b0;
    @(negedge clk);
    checks++;
    if ({lite_r_valid, lite_r_data, lite_r_id} !== {1'b1, 32'hBBBBCCCC, 1'b1}) begin
      errors++;
      $display("FAIL bp_back_to_back got valid %b data %h id %h exp 1 bbbbcccc 1", lite_r_valid, lite_r_data, lite_r_id);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_malformed();
    send_ar(1'b1, 12'h00C);
    @(posedge clk); #1;
    send_r(64'hDEADBEEF_FEEDFACE, 1'b0, 2'b00);
    @(negedge clk);
    checks++;
    if ({lite_r_valid, lite_r_resp, lite_r_data} !== {1'b1, 2'b10, 32'hDEADBEEF}) begin
      errors++;
      $display("FAIL malformed_resp got valid %b resp %h data %h exp 1 2 deadbeef", lite_r_valid, lite_r_resp, lite_r_data);
    end
    @(posedge clk); #1;
    @(negedge clk);
    checks++;
    if (nasti_r_ready !== 1'b0) begin errors++; $display("FAIL malformed_count got nasti_r_ready %b exp 0", nasti_r_ready); end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid();
    send_ar(1'b0, 12'h010);
    send_ar(1'b1, 12'h014);
    @(posedge clk); #1;
    do_reset();
    send_ar(1'b1, 12'h01C);
    @(posedge clk); #1;
    send_r(64'h76543210_FEDCBA98, 1'b1, 2'b00);
    @(negedge clk);
    checks++;
    if ({lite_r_valid, lite_r_id, lite_r_data} !== {1'b1, 1'b1, 32'h76543210}) begin
      errors++;
      $display("FAIL reset_mid_read got valid %b id %h data %h exp 1 1 76543210", lite_r_valid, lite_r_id, lite_r_data);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_random();
    for (int i = 0; i < 6; i++) begin
      send_ar(1'($urandom), 12'($urandom));
      send_ar(1'($urandom), 12'($urandom));
      send_r({$urandom, $urandom}, 1'($urandom_range(3, 0) != 0), 2'($urandom));
      send_r({$urandom, $urandom}, 1'b1, 2'($urandom));
    end
    repeat (3) @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    lite_ar_valid = 1'b0; lite_ar_id = '0; lite_ar_addr = '0; lite_ar_prot = '0;
    lite_ar_qos = '0; lite_ar_region = '0; lite_ar_user = '0;
    lite_r_ready = 1'b1;
    nasti_ar_ready = 1'b1;
    nasti_r_valid = 1'b0; nasti_r_id = '0; nasti_r_data = '0; nasti_r_resp = '0;
    nasti_r_last = 1'b0; nasti_r_user = '0;
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    test_lane1();
    test_lane0();
    test_full();
    test_backpressure();
    test_malformed();
    test_reset_mid();
    test_random();
    checks++;
    if (ar_q.size() != 0 || trk_q.size() != 0 || r_q.size() != 0) begin
      errors++;
      $display("FAIL drain got ar %0d trk %0d r %0d exp 0 0 0", ar_q.size(), trk_q.size(), r_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/lite_nasti_reader.md
# lite_nasti_reader

Read-channel upsizer from a NASTI-Lite master (narrow, single-beat) to a full NASTI slave (wide data). It sits between Lite-only masters (debug/peripheral DMA, boot loaders) and the wide NASTI memory fabric. It is the reverse of the existing NASTI-to-Lite reader path. Each Lite read becomes one single-beat NASTI burst. The correct Lite lane is extracted from the wide response, and the original ID/order is restored from an in-order tracker.

## Interface
Parameters:
- MAX_TRANSACTION, 2, maximum outstanding reads (tracker depth, ≥1)
- ID_WIDTH, 1, Lite ID width
- ADDR_WIDTH, 12, address width (both sides)
- NASTI_DATA_WIDTH, 64, wide-side data width
- LITE_DATA_WIDTH, 32, Lite-side data width; NASTI_DATA_WIDTH/LITE_DATA_WIDTH is a power of two ≥1
- USER_WIDTH, 1, user field width (>0)

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- lite_ar_id/addr/prot/qos/region/user  in  ID_WIDTH/ADDR_WIDTH/3/4/4/USER_WIDTH  Lite read request
- lite_ar_valid  in  1;  lite_ar_ready  out  1
- lite_r_id/data/resp/user  out  ID_WIDTH/LITE_DATA_WIDTH/2/USER_WIDTH  Lite read response
- lite_r_valid  out  1;  lite_r_ready  in  1
- nasti_ar_id/addr/len/size/burst/lock/cache/prot/qos/region/user  out  ID_WIDTH/ADDR_WIDTH/8/3/2/1/4/3/4/4/USER_WIDTH  NASTI request
- nasti_ar_valid  out  1;  nasti_ar_ready  in  1
- nasti_r_id/data/resp/last/user  in  ID_WIDTH/NASTI_DATA_WIDTH/2/1/USER_WIDTH  NASTI response
- nasti_r_valid  in  1;  nasti_r_ready  out  1

## Operation
- AR path uses a one-entry output register.
- lite_ar_ready = !rst && count<MAX_TRANSACTION && (!nasti_ar_valid || nasti_ar_ready).
- On Lite AR accept, the register loads:
  - addr, prot, qos, region, user: copied from the Lite request.
  - nasti_ar_id = 0, so all traffic is same-ID and the slave must return it in order.
  - len = 0, size = log2(LITE_DATA_WIDTH/8), burst = INCR (2'b01), lock = 0, cache = 4'b0000.
- On the same accept, the tracker pushes {lite id, lane}.
  - lane = addr[log2(NASTI_DATA_WIDTH/8)-1 : log2(LITE_DATA_WIDTH/8)]; lane is 0-width when the two widths are equal.
- count is incremented on AR accept and decremented on NASTI R accept. Both in one cycle leaves count unchanged.
- R path uses a one-entry output register.
- nasti_r_ready = !rst && count≠0 && (!lite_r_valid || lite_r_ready). R beats are never accepted with the tracker empty.
- On NASTI R accept, the tracker pops its head and the Lite R register loads:
  - lite_r_data = nasti_r_data[lane*LITE_DATA_WIDTH +: LITE_DATA_WIDTH]
  - lite_r_id = tracker id
  - lite_r_user = nasti_r_user
  - lite_r_resp = nasti_r_last ? nasti_r_resp : 2'b10 (SLVERR on a malformed multi-beat response; the beat is still consumed as a complete transaction)
- nasti_r_id is ignored.

## Timing
- Reset (rst high at a clock edge) clears count, tracker pointers, nasti_ar_valid and lite_r_valid. All ready outputs are 0 while rst is high.
- Other output registers are don't-care in reset; they are driven 0 for determinism.
- Reset mid-operation drops all outstanding transactions silently. The system resets the slave together with the bridge.
- AR latency: Lite AR handshake in cycle N → nasti_ar_valid in cycle N+1.
- R latency: NASTI R handshake in cycle N → lite_r_valid in cycle N+1.
- Full throughput: one transaction per cycle per channel with no backpressure.
- Valid-hold rule: nasti_ar_valid and lite_r_valid, once asserted, hold with stable payload until their handshake.
- Full condition: with count==MAX_TRANSACTION, lite_ar_ready is 0 even if an R beat pops in the same cycle. A new request is accepted in the next cycle.
- No combinational path from lite_ar_valid to nasti_ar_valid, or from nasti_r_valid to lite_r_valid.

## Structure
- Shared package nasti_pkg holds:
  - BURST_INCR and RESP_OKAY/EXOKAY/SLVERR/DECERR constants
  - a function size_of_bytes(n) → 3-bit AxSIZE
- Local localparams: LANES, LANE_W, TRACK_W.
- Tracker is the sub-module nasti_lite_fifo: synchronous FIFO, parameters DEPTH and WIDTH, ports push/pop/din/dout/full/empty. Pointers wrap modulo DEPTH.

## Test plan
- Single read, lane 1: lite_ar addr 0x004, id 1 → nasti_ar addr 0x004, len 0, size 2, burst 01, id 0. Then r_data 0x1122334455667788, last 1, resp 00 → lite_r data 0x11223344, id 1, resp 00, one cycle after.
- Lane 0: addr 0x008 → lite_r data 0x55667788.
- Full: MAX_TRANSACTION=2, issue 2 reads with no R → lite_ar_ready 0. Return one R → ready 1 the next cycle, and the returned IDs keep issue order 0 then 1.
- Backpressure: hold lite_r_ready 0 with lite_r_valid 1 → nasti_r_ready 0 and lite_r payload stable. Release → back-to-back beats at full rate.
- Malformed: R beat with last 0, resp 00 → lite_r_resp 10 and count decremented.
- Reset with 2 outstanding: rst 1 cycle → valids 0, count 0. Next read completes normally.
